// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: frame geometry, sample format
// and the complex/frame types used by both the loader and the FFT core.
package fft_pkg;

  localparam int N        = 4;   // samples per frame, power of two, >= 2
  localparam int W        = 15;  // sample MSB index (W+1 bit samples)
  localparam int BIT_FRAC = 8;   // fractional bits, carried through untouched
  localparam int CNT_W    = $clog2(N);

  // Component selectors inside a complex sample
  localparam int RE = 0;
  localparam int IM = 1;

  typedef logic signed [W:0] sample_t;
  typedef sample_t [1:0]     cplx_t;
  typedef cplx_t [N-1:0]     frame_t;

  // True when a write index addresses the final slot of a frame
  function automatic logic is_last_slot(input logic [CNT_W-1:0] idx);
    return (idx == CNT_W'(N - 1));
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample-stream and frame-output handshakes of the frame loader.
// master = the surrounding system (sample source + FFT capture),
// slave  = the loader itself.
interface fft_frame_loader_if;
  import fft_pkg::*;

  logic    in_valid;
  logic    in_ready;
  sample_t in_re;
  sample_t in_im;
  logic    in_last;
  logic    frame_valid;
  logic    frame_ready;
  frame_t  frame_x;
  logic    align_err;

  modport master (
    output in_valid, in_re, in_im, in_last, frame_ready,
    input  in_ready, frame_valid, frame_x, align_err
  );

  modport slave (
    input  in_valid, in_re, in_im, in_last, frame_ready,
    output in_ready, frame_valid, frame_x, align_err
  );

endinterface

// File: rtl/fft_frame_bank.sv
// One N-entry complex sample bank: single indexed write port and a
// full-frame parallel read port. Contents are deliberately not reset;
// validity is tracked by the loader's full flags.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [CNT_W-1:0] idx_i,
  input  cplx_t            din_i,
  output frame_t           frame_o
);

  frame_t mem_q;

  // Store one complex sample at the addressed slot when enabled
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= din_i;
    end
  end

  assign frame_o = mem_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame assembler in front of the combinational FFT core.
// Samples stream into the write bank; a completed bank is held as a
// parallel frame under frame_valid/frame_ready while the other bank fills.
module fft_frame_loader
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fft_frame_loader_if.slave  bus
);

  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             align_err_q, align_err_d;

  logic             in_ready_s;
  logic             frame_valid_s;
  logic             accept_s;
  logic             drain_s;
  logic             last_slot_s;
  logic [1:0]       bank_we_s;
  cplx_t            din_s;
  frame_t           frame0_s;
  frame_t           frame1_s;

  // Ready depends only on registered state, so a drain in this cycle
  // cannot combinationally open the input; it shows up a cycle later.
  assign in_ready_s    = ~bank_full_q[wr_bank_q];
  assign frame_valid_s = bank_full_q[rd_bank_q];
  assign accept_s      = bus.in_valid & in_ready_s;
  assign drain_s       = frame_valid_s & bus.frame_ready;
  assign last_slot_s   = is_last_slot(wr_cnt_q);

  assign din_s[RE] = bus.in_re;
  assign din_s[IM] = bus.in_im;

  // Route the write strobe to whichever bank is currently filling
  always_comb begin
    bank_we_s = 2'b00;
    if (accept_s) begin
      bank_we_s[wr_bank_q] = 1'b1;
    end else begin
      bank_we_s = 2'b00;
    end
  end

  fft_frame_bank u_bank0 (
    .clk     (clk),
    .we_i    (bank_we_s[0]),
    .idx_i   (wr_cnt_q),
    .din_i   (din_s),
    .frame_o (frame0_s)
  );

  fft_frame_bank u_bank1 (
    .clk     (clk),
    .we_i    (bank_we_s[1]),
    .idx_i   (wr_cnt_q),
    .din_i   (din_s),
    .frame_o (frame1_s)
  );

  // Next-state for fill position, bank pointers, full flags and framing error
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    bank_full_d = bank_full_q;
    align_err_d = 1'b0;

    // Drain and fill completion always target different banks: a drain
    // needs rd bank full, an accept needs wr bank empty.
    if (drain_s) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end

    if (accept_s) begin
      // Any mismatch between in_last and slot position is a framing error
      align_err_d = last_slot_s ^ bus.in_last;
      if (last_slot_s) begin
        // Full frame (with or without in_last): hand it over
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        wr_cnt_d               = {CNT_W{1'b0}};
      end else if (bus.in_last) begin
        // Short frame: drop it and restart the bank from slot 0
        wr_cnt_d = {CNT_W{1'b0}};
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // Control state register with synchronous reset; bank data is untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= {CNT_W{1'b0}};
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      align_err_q <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bank_full_q <= bank_full_d;
      align_err_q <= align_err_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.frame_valid = frame_valid_s;
  assign bus.frame_x     = rd_bank_q ? frame1_s : frame0_s;
  assign bus.align_err   = align_err_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: directed scenarios plus a
// randomized run, all observed by a frame-queue reference model.
module tb_fft_frame_loader;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft_frame_loader_if lif();

  fft_frame_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (lif)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int frames_seen = 0;
  int errs_seen   = 0;

  // Reference model: completed frames awaiting handshake, the frame being
  // gathered, and the error pulse expected on the next cycle.
  frame_t exp_q[$];
  cplx_t  part_q[$];
  logic   exp_err = 1'b0;
  logic   mon_en  = 1'b0;
  logic   mon_acc;
  frame_t mon_f;
  logic   rnd_done;

  // Per-cycle model check, sampled on the falling edge
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      exp_q.delete();
      part_q.delete();
      exp_err = 1'b0;
    end else begin
      vectors += 3;
      if (lif.in_ready !== (exp_q.size() < 2)) begin
        miscompares++;
        $display("FAIL mon_in_ready t=%0t: got %b want %b", $time, lif.in_ready, exp_q.size() < 2);
      end
      if (lif.frame_valid !== (exp_q.size() != 0)) begin
        miscompares++;
        $display("FAIL mon_frame_valid t=%0t: got %b want %b", $time, lif.frame_valid, exp_q.size() != 0);
      end
      if (lif.align_err !== exp_err) begin
        miscompares++;
        $display("FAIL mon_align_err t=%0t: got %b want %b", $time, lif.align_err, exp_err);
      end
      if (exp_q.size() != 0) begin
        vectors++;
        if (lif.frame_x !== exp_q[0]) begin
          miscompares++;
          $display("FAIL mon_frame_x t=%0t: got %h want %h", $time, lif.frame_x, exp_q[0]);
        end
      end
      if (lif.align_err === 1'b1) errs_seen++;
      if (lif.frame_valid === 1'b1 && lif.frame_ready === 1'b1) frames_seen++;

      // Advance the model to the state after the coming rising edge
      exp_err = 1'b0;
      mon_acc = lif.in_valid && (exp_q.size() < 2);
      if (exp_q.size() != 0 && lif.frame_ready) void'(exp_q.pop_front());
      if (mon_acc) begin
        part_q.push_back({lif.in_im, lif.in_re});
        if (part_q.size() == N) begin
          for (int k = 0; k < N; k++) mon_f[k] = part_q[k];
          exp_q.push_back(mon_f);
          part_q.delete();
          exp_err = !lif.in_last;
        end else if (lif.in_last) begin
          part_q.delete();
          exp_err = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted (bounded wait)
  task automatic send(input int re, input int im, input logic last);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    lif.in_valid = 1'b1;
    lif.in_re    = sample_t'(re);
    lif.in_im    = sample_t'(im);
    lif.in_last  = last;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = (lif.in_ready === 1'b1);
      tick();
      n++;
    end
    lif.in_valid = 1'b0;
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL send_timeout: sample re=%0d not accepted after %0d cycles", re, n);
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    lif.in_valid    = 1'b0;
    lif.in_last     = 1'b0;
    lif.in_re       = '0;
    lif.in_im       = '0;
    lif.frame_ready = 1'b0;
    repeat (3) tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    vectors += 3;
    if (lif.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b want 1", lif.in_ready);
    end
    if (lif.frame_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_frame_valid: got %b want 0", lif.frame_valid);
    end
    if (lif.align_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_align_err: got %b want 0", lif.align_err);
    end
    tick();
  endtask

  task automatic test_ramp();
    lif.frame_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(k <<< 8, (3 - k) <<< 8, k == 3);
    @(negedge clk);
    vectors++;
    if (lif.frame_valid !== 1'b1) begin
      miscompares++; $display("FAIL ramp_valid: got %b want 1", lif.frame_valid);
    end
    for (int k = 0; k < 4; k++) begin
      vectors += 2;
      if (lif.frame_x[k][0] !== sample_t'(k * 256)) begin
        miscompares++; $display("FAIL ramp_re[%0d]: got %0d want %0d", k, lif.frame_x[k][0], k * 256);
      end
      if (lif.frame_x[k][1] !== sample_t'((3 - k) * 256)) begin
        miscompares++; $display("FAIL ramp_im[%0d]: got %0d want %0d", k, lif.frame_x[k][1], (3 - k) * 256);
      end
    end
    tick();
  endtask

  task automatic test_back_pressure();
    int f0;
    f0 = frames_seen;
    lif.frame_ready = 1'b0;
    for (int v = 1; v <= 8; v++) send(v, -v, (v % 4) == 0);
    lif.in_valid = 1'b1;
    lif.in_re    = sample_t'(9);
    lif.in_im    = sample_t'(-9);
    lif.in_last  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors += 2;
      if (lif.in_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_stall[%0d]: in_ready got %b want 0", c, lif.in_ready);
      end
      if (lif.frame_x[0][0] !== sample_t'(1)) begin
        miscompares++; $display("FAIL bp_hold[%0d]: re0 got %0d want 1", c, lif.frame_x[0][0]);
      end
      tick();
    end
    lif.frame_ready = 1'b1;
    for (int v = 9; v <= 12; v++) send(v, -v, (v % 4) == 0);
    repeat (4) tick();
    vectors++;
    if (frames_seen - f0 !== 3) begin
      miscompares++; $display("FAIL bp_frames: got %0d want 3", frames_seen - f0);
    end
  endtask

  task automatic test_streaming();
    int stalls;
    int vc[$];
    stalls = 0;
    lif.frame_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) send(100 + i, -i, (i % 4) == 3);
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          if (lif.in_valid && !lif.in_ready) stalls++;
          if (lif.frame_valid === 1'b1) vc.push_back(c);
        end
      end
    join
    vectors += 2;
    if (stalls !== 0) begin
      miscompares++; $display("FAIL stream_stalls: got %0d want 0", stalls);
    end
    if (vc.size() !== 3) begin
      miscompares++; $display("FAIL stream_pulses: got %0d want 3", vc.size());
    end else begin
      vectors += 2;
      if (vc[1] - vc[0] !== 4) begin
        miscompares++; $display("FAIL stream_gap1: got %0d want 4", vc[1] - vc[0]);
      end
      if (vc[2] - vc[1] !== 4) begin
        miscompares++; $display("FAIL stream_gap2: got %0d want 4", vc[2] - vc[1]);
      end
    end
    tick();
  endtask

  task automatic test_early_last();
    int f0;
    int e0;
    f0 = frames_seen;
    e0 = errs_seen;
    lif.frame_ready = 1'b1;
    send(1, 0, 1'b0);
    send(2, 0, 1'b1);
    @(negedge clk);
    vectors++;
    if (lif.align_err !== 1'b1) begin
      miscompares++; $display("FAIL early_err: got %b want 1", lif.align_err);
    end
    tick();
    for (int v = 7; v <= 10; v++) send(v, 0, v == 10);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (lif.frame_x[k][0] !== sample_t'(7 + k)) begin
        miscompares++; $display("FAIL early_re[%0d]: got %0d want %0d", k, lif.frame_x[k][0], 7 + k);
      end
    end
    tick();
    vectors += 2;
    if (frames_seen - f0 !== 1) begin
      miscompares++; $display("FAIL early_frames: got %0d want 1", frames_seen - f0);
    end
    if (errs_seen - e0 !== 1) begin
      miscompares++; $display("FAIL early_errs: got %0d want 1", errs_seen - e0);
    end
  endtask

  task automatic test_missing_last();
    lif.frame_ready = 1'b1;
    for (int v = 20; v < 24; v++) send(v, v, 1'b0);
    @(negedge clk);
    vectors += 2;
    if (lif.frame_valid !== 1'b1) begin
      miscompares++; $display("FAIL miss_valid: got %b want 1", lif.frame_valid);
    end
    if (lif.align_err !== 1'b1) begin
      miscompares++; $display("FAIL miss_err: got %b want 1", lif.align_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int f0;
    lif.frame_ready = 1'b0;
    for (int v = 40; v < 44; v++) send(v, 0, v == 43);
    send(50, 0, 1'b0);
    send(51, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lif.frame_ready = 1'b1;
    f0 = frames_seen;
    @(negedge clk);
    vectors += 2;
    if (lif.frame_valid !== 1'b0) begin
      miscompares++; $display("FAIL rmid_valid: got %b want 0", lif.frame_valid);
    end
    if (lif.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rmid_ready: got %b want 1", lif.in_ready);
    end
    tick();
    for (int k = 1; k <= 4; k++) send(-(k * 256), 0, k == 4);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (lif.frame_x[k][0] !== sample_t'(-((k + 1) * 256))) begin
        miscompares++; $display("FAIL rmid_re[%0d]: got %0d want %0d", k, lif.frame_x[k][0], -((k + 1) * 256));
      end
    end
    tick();
    repeat (3) tick();
    vectors++;
    if (frames_seen - f0 !== 1) begin
      miscompares++; $display("FAIL rmid_frames: got %0d want 1", frames_seen - f0);
    end
  endtask

  task automatic test_random();
    int   p;
    logic last;
    p        = 0;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          last = (p == N - 1);
          if ($urandom_range(0, 9) == 0) last = !last;
          send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, last);
          p = (last || p == N - 1) ? 0 : p + 1;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          lif.frame_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
      end
    join
    lif.frame_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    vectors += 2;
    if (lif.frame_valid !== 1'b0) begin
      miscompares++; $display("FAIL rand_drained: got %b want 0", lif.frame_valid);
    end
    if (lif.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rand_ready: got %b want 1", lif.in_ready);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_back_pressure();
    test_streaming();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
